// File: rtl/color_manager_config_regs_pkg.sv
// Shared definitions for the configuration register block: address map,
// reset codes, FSM state encoding and color table geometry.
package color_manager_config_regs_pkg;

  localparam int C_ADDR_WIDTH = 3;
  localparam int C_DATA_WIDTH = 14;
  localparam int COLOR_WIDTH  = 12;
  localparam int NUM_COLORS   = 4;
  localparam int PTR_WIDTH    = 2;
  localparam int FIELD_WIDTH  = 3;

  localparam logic [C_ADDR_WIDTH-1:0] ADDR_BAUD   = 3'd0;
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_PARITY = 3'd1;
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_STOP   = 3'd2;
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_RES    = 3'd3;
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_QUAD   = 3'd4;
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_COLOR  = 3'd5;

  localparam logic [2:0] BAUD_RESET   = 3'd2;  // 9600 baud
  localparam logic [1:0] PARITY_RESET = 2'd0;
  localparam logic       STOP_RESET   = 1'b0;
  localparam logic [1:0] RES_RESET    = 2'd0;
  localparam logic [1:0] QUAD_RESET   = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_UART = 2'd1,
    ST_WAIT_VGA  = 2'd2,
    ST_COMMIT    = 2'd3
  } state_e;

  // Only the low three data bits matter for any deferred field.
  typedef struct packed {
    logic [C_ADDR_WIDTH-1:0] addr;
    logic [FIELD_WIDTH-1:0]  field;
  } shadow_t;

  function automatic logic is_uart_addr(input logic [C_ADDR_WIDTH-1:0] addr);
    return (addr == ADDR_BAUD) || (addr == ADDR_PARITY) || (addr == ADDR_STOP);
  endfunction

endpackage

// File: rtl/color_manager_wait_timer.sv
// Saturating wait counter; timeout_o is high once the count reaches
// TIMEOUT_CYCLES-1 and stays there until cleared.
module color_manager_wait_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic Clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !timeout_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/color_manager_config_regs.sv
// Live UART/VGA configuration registers and color table; UART fields commit
// only while the UART is idle, VGA fields only at a frame boundary.
module color_manager_config_regs
  import color_manager_config_regs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                            Clk,
  input  logic                            rst,
  input  logic [C_ADDR_WIDTH-1:0]         C_Addr,
  input  logic [C_DATA_WIDTH-1:0]         C_Data,
  input  logic                            C_Valid,
  output logic                            C_Rdy,
  input  logic                            Uart_Busy,
  input  logic                            Vga_Frame_End,
  output logic [2:0]                      Baud_Sel,
  output logic [1:0]                      Parity_Sel,
  output logic                            Stop_Sel,
  output logic                            Uart_Cfg_Update,
  output logic [1:0]                      Res_Sel,
  output logic [1:0]                      Quad_Sel,
  output logic                            Vga_Cfg_Update,
  output logic [NUM_COLORS*COLOR_WIDTH-1:0] Color_Table,
  output logic [PTR_WIDTH-1:0]            Color_Wr_Ptr,
  output logic                            Addr_Error,
  output logic                            Apply_Timeout
);

  state_e  state_q, state_d;
  shadow_t shadow_q, shadow_d;

  logic                 c_rdy_q;
  logic [2:0]           baud_q;
  logic [1:0]           parity_q;
  logic                 stop_q;
  logic [1:0]           res_q;
  logic [1:0]           quad_q;
  logic                 uart_upd_q;
  logic                 vga_upd_q;
  logic                 addr_err_q, addr_err_d;
  logic                 timeout_q;
  logic [PTR_WIDTH-1:0] ptr_q;

  logic commit_en;
  logic forced;
  logic color_we;
  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  // The top data bits are never consumed by any field or color entry.
  logic unused_data_bits;
  assign unused_data_bits = ^C_Data[C_DATA_WIDTH-1:COLOR_WIDTH];

  color_manager_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .Clk      (Clk),
    .rst      (rst),
    .clear_i  (timer_clr),
    .en_i     (timer_en),
    .timeout_o(timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    commit_en  = 1'b0;
    forced     = 1'b0;
    color_we   = 1'b0;
    addr_err_d = 1'b0;
    timer_clr  = 1'b1;
    timer_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (C_Valid) begin
          case (C_Addr)
            ADDR_BAUD, ADDR_PARITY, ADDR_STOP: begin
              shadow_d = '{addr: C_Addr, field: C_Data[FIELD_WIDTH-1:0]};
              state_d  = ST_WAIT_UART;
            end
            ADDR_RES, ADDR_QUAD: begin
              shadow_d = '{addr: C_Addr, field: C_Data[FIELD_WIDTH-1:0]};
              state_d  = ST_WAIT_VGA;
            end
            ADDR_COLOR: color_we = 1'b1;
            default:    addr_err_d = 1'b1;
          endcase
        end
      end
      ST_WAIT_UART: begin
        timer_clr = 1'b0;
        if (!Uart_Busy) begin
          state_d   = ST_COMMIT;
          commit_en = 1'b1;
        end else if (timer_expired) begin
          state_d   = ST_COMMIT;
          commit_en = 1'b1;
          forced    = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_WAIT_VGA: begin
        timer_clr = 1'b0;
        // A frame end on the timeout cycle still counts as a normal commit.
        if (Vga_Frame_End) begin
          state_d   = ST_COMMIT;
          commit_en = 1'b1;
        end else if (timer_expired) begin
          state_d   = ST_COMMIT;
          commit_en = 1'b1;
          forced    = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Active registers and pulses are loaded on the edge entering COMMIT so
  // they are visible together during the COMMIT cycle.
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      c_rdy_q    <= 1'b1;
      baud_q     <= BAUD_RESET;
      parity_q   <= PARITY_RESET;
      stop_q     <= STOP_RESET;
      res_q      <= RES_RESET;
      quad_q     <= QUAD_RESET;
      uart_upd_q <= 1'b0;
      vga_upd_q  <= 1'b0;
      addr_err_q <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      c_rdy_q    <= (state_d == ST_IDLE);
      addr_err_q <= addr_err_d;
      uart_upd_q <= commit_en && is_uart_addr(shadow_q.addr);
      vga_upd_q  <= commit_en && !is_uart_addr(shadow_q.addr);
      timeout_q  <= forced;
      if (commit_en) begin
        case (shadow_q.addr)
          ADDR_BAUD:   baud_q   <= shadow_q.field;
          ADDR_PARITY: parity_q <= shadow_q.field[1:0];
          ADDR_STOP:   stop_q   <= shadow_q.field[0];
          ADDR_RES:    res_q    <= shadow_q.field[1:0];
          ADDR_QUAD:   quad_q   <= shadow_q.field[1:0];
          default:     ;
        endcase
      end
      if (commit_en && (shadow_q.addr == ADDR_QUAD)) begin
        ptr_q <= '0;
      end else if (color_we) begin
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_COLORS; gi++) begin : g_color
      logic [COLOR_WIDTH-1:0] entry_q;
      always_ff @(posedge Clk) begin
        if (rst) begin
          entry_q <= '0;
        end else if (color_we && (ptr_q == PTR_WIDTH'(gi))) begin
          entry_q <= C_Data[COLOR_WIDTH-1:0];
        end
      end
      assign Color_Table[gi*COLOR_WIDTH +: COLOR_WIDTH] = entry_q;
    end
  endgenerate

  assign C_Rdy           = c_rdy_q;
  assign Baud_Sel        = baud_q;
  assign Parity_Sel      = parity_q;
  assign Stop_Sel        = stop_q;
  assign Uart_Cfg_Update = uart_upd_q;
  assign Res_Sel         = res_q;
  assign Quad_Sel        = quad_q;
  assign Vga_Cfg_Update  = vga_upd_q;
  assign Color_Wr_Ptr    = ptr_q;
  assign Addr_Error      = addr_err_q;
  assign Apply_Timeout   = timeout_q;

endmodule

// File: doc/color_manager_config_regs.md
Name: color_manager_config_regs

Overview:
Downstream consumer of the configuration manager's C_Addr/C_Data/C_Valid/C_Rdy stream. It holds the live UART and VGA configuration registers and a 4-entry color table, and drives C_Rdy back to the manager. UART changes are committed only while the UART is idle, and VGA changes only at a frame boundary, so a change never takes effect mid-character or mid-frame. Its outputs feed the UART core and the VGA timing/pixel path.

Parameters:
C_ADDR_WIDTH, 3, config address width
C_DATA_WIDTH, 14, config data width
COLOR_WIDTH, 12, RGB 4:4:4 color width; taken from C_Data[11:0]
NUM_COLORS, 4, color table depth, one entry per quadrant
TIMEOUT_CYCLES, 1000000, maximum cycles spent waiting for an idle UART or a frame end; minimum 2

Ports:
Clk  in  1  clock
rst  in  1  synchronous reset, active-high
C_Addr  in  C_ADDR_WIDTH  config address
C_Data  in  C_DATA_WIDTH  config data
C_Valid  in  1  one-cycle config strobe; upstream pulses it only while C_Rdy=1
C_Rdy  out  1  block can accept a transaction
Uart_Busy  in  1  UART TX or RX is active
Vga_Frame_End  in  1  one-cycle pulse at the end of the last visible line
Baud_Sel  out  3  active baud code
Parity_Sel  out  2  active parity code
Stop_Sel  out  1  active stop-bit code
Uart_Cfg_Update  out  1  one-cycle pulse when the UART fields change
Res_Sel  out  2  active resolution code
Quad_Sel  out  2  active quadrant-split code
Vga_Cfg_Update  out  1  one-cycle pulse when the VGA fields change
Color_Table  out  NUM_COLORS*COLOR_WIDTH  entry i occupies bits [i*12+:12]
Color_Wr_Ptr  out  2  index of the next color entry to be written
Addr_Error  out  1  one-cycle pulse on an unknown address
Apply_Timeout  out  1  one-cycle pulse when a commit is forced

Behaviour:
- Address map (shared package): 0 baud, 1 parity, 2 stop, 3 resolution, 4 quadrant, 5 color; 6 and 7 are invalid.
- Reset values (rst high at a Clk edge):
  - state IDLE, C_Rdy=1;
  - Baud_Sel=2 (9600), Parity_Sel=0, Stop_Sel=0, Res_Sel=0, Quad_Sel=0;
  - Color_Table=0, Color_Wr_Ptr=0;
  - all pulse outputs 0, timeout counter 0, shadow register cleared.
- A reset during WAIT_UART or WAIT_VGA discards the pending value; no update pulse is issued.
- States are IDLE, WAIT_UART, WAIT_VGA, COMMIT. C_Rdy=1 only in IDLE; it is a registered output.
- IDLE, on C_Valid=1:
  - Addresses 0-4: latch {addr, data} into the shadow register. Next state is WAIT_UART for addresses 0-2 and WAIT_VGA for 3-4. C_Rdy=0 from the next cycle.
  - Address 5: the write completes in the same edge. Color_Table[Color_Wr_Ptr] <= C_Data[11:0] and Color_Wr_Ptr increments modulo 4 (3->0). State stays IDLE and C_Rdy stays 1.
  - Address 6 or 7: Addr_Error pulses the next cycle, no register changes, state stays IDLE.
- C_Valid while C_Rdy=0 is ignored; this is an upstream protocol violation and produces no error output.
- WAIT_UART:
  - Uart_Busy=0 in any cycle -> COMMIT.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 -> COMMIT with the forced flag set.
- WAIT_VGA: same as WAIT_UART, using Vga_Frame_End=1 as the exit condition. If Vga_Frame_End=1 coincides with the timeout, the commit is normal and Apply_Timeout does not pulse.
- COMMIT, one cycle:
  - Write the shadow field into the addressed active register.
  - Pulse Uart_Cfg_Update (addresses 0-2) or Vga_Cfg_Update (3-4) in this cycle.
  - A quadrant commit also clears Color_Wr_Ptr to 0.
  - Apply_Timeout pulses in this cycle if the forced flag is set.
  - Clear the counter and the flag, then -> IDLE.
- Data slicing: baud uses C_Data[2:0], parity [1:0], stop [0], resolution [1:0], quadrant [1:0]. Value legality is checked upstream and is not rechecked here.
- Latency: a config accepted at edge N with its exit condition true during cycle N+1 produces COMMIT and the update pulse in cycle N+2. C_Rdy returns in cycle N+3.

Decomposition:
- Shared package holds: address codes, reset/default codes, state encoding, and the COLOR_WIDTH/NUM_COLORS constants.
- One natural sub-module: color_manager_wait_timer. It is the saturating cycle counter, with clear/enable inputs and a timeout output, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Reset, then write address 0 data 4 with Uart_Busy=0 -> Uart_Cfg_Update pulses 2 cycles after acceptance, Baud_Sel=4, C_Rdy=1 the following cycle.
2. Write address 1 data 2 with Uart_Busy=1 held for 10 cycles -> Parity_Sel stays 0 and C_Rdy=0 until Uart_Busy falls, then Parity_Sel=2 with one Uart_Cfg_Update pulse.
3. TIMEOUT_CYCLES=16, write address 3 data 1 with no Vga_Frame_End -> COMMIT at the 16th wait cycle, Res_Sel=1, Vga_Cfg_Update and Apply_Timeout pulse together.
4. Five color writes 0x111, 0x222, 0x333, 0x444, 0x555 -> entries {0x555, 0x222, 0x333, 0x444}, Color_Wr_Ptr=1, C_Rdy never drops.
5. Write address 4 data 2 committed on Vga_Frame_End -> Quad_Sel=2, Color_Wr_Ptr=0. Then write address 7 -> Addr_Error pulse, no outputs change.
6. Assert rst during WAIT_UART after a baud write of 5 -> Baud_Sel=2, no Uart_Cfg_Update pulse, C_Rdy=1 after reset.
